// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared types and constants for the switch input conditioner
package input_conditioner_pkg;
    typedef enum logic [1:0] {DB_ZERO, DB_WAIT1, DB_ONE, DB_WAIT0} db_state_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizer, debounce FSM and rising-edge tick for one raw switch
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic tick
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DB_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    db_state_t state, state_nxt;
    logic s, tick_nxt;
    assign s = sync[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            state <= DB_ZERO;
            cnt   <= '0;
            tick  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tick  <= tick_nxt;
        end
    end
    // any disagreement during a WAIT state drops back with no partial credit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            DB_ZERO:  if (s) begin
                state_nxt = DB_WAIT1;
                cnt_nxt   = LOAD;
            end
            DB_WAIT1: if (!s) state_nxt = DB_ZERO;
                      else if (cnt == '0) state_nxt = DB_ONE;
                      else cnt_nxt = cnt - 1'b1;
            DB_ONE:   if (!s) begin
                state_nxt = DB_WAIT0;
                cnt_nxt   = LOAD;
            end
            DB_WAIT0: if (s) state_nxt = DB_ONE;
                      else if (cnt == '0) state_nxt = DB_ZERO;
                      else cnt_nxt = cnt - 1'b1;
            default:  state_nxt = DB_ZERO;
        endcase
    end
    always_comb begin
        level    = (state == DB_ONE) || (state == DB_WAIT0);
        tick_nxt = (state == DB_WAIT1) && (state_nxt == DB_ONE);
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: two independent debounced switch channels with rising-edge ticks
module input_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_tick,
    output logic b_tick
);
    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_a (
        .clk(clk), .reset(reset), .raw(sw_a_raw), .level(a), .tick(a_tick)
    );
    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_b (
        .clk(clk), .reset(reset), .raw(sw_b_raw), .level(b), .tick(b_tick)
    );
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: run-length reference model check of DB_CYCLES=4 and DB_CYCLES=1 builds
module tb_input_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sw_a_raw = 1'b1;
    logic sw_b_raw = 1'b1;
    logic a4, b4, at4, bt4, a1, b1, at1, bt1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    input_conditioner #(.DB_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .sw_a_raw(sw_a_raw), .sw_b_raw(sw_b_raw),
        .a(a4), .b(b4), .a_tick(at4), .b_tick(bt4)
    );
    input_conditioner #(.DB_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .sw_a_raw(sw_a_raw), .sw_b_raw(sw_b_raw),
        .a(a1), .b(b1), .a_tick(at1), .b_tick(bt1)
    );

    // Model: a level flips once the synchronized input has disagreed with it
    // on DB_CYCLES+1 consecutive edges; channels 0/1 are dut4 a/b, 2/3 are dut1 a/b.
    int   run [4] = '{default: 0};
    logic lvl [4] = '{default: 1'b0};
    logic tk  [4] = '{default: 1'b0};
    logic r1  [4] = '{default: 1'b0};
    logic r2  [4] = '{default: 1'b0};
    logic s_m;

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset) begin
                run[i] = 0; lvl[i] = 1'b0; tk[i] = 1'b0; r1[i] = 1'b0; r2[i] = 1'b0;
            end else begin
                s_m   = r2[i];
                r2[i] = r1[i];
                r1[i] = (i % 2 == 0) ? sw_a_raw : sw_b_raw;
                tk[i] = 1'b0;
                if (s_m != lvl[i]) begin
                    run[i]++;
                    if (run[i] == ((i < 2) ? 4 : 1) + 1) begin
                        lvl[i] = s_m;
                        tk[i]  = s_m;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("a4", a4, lvl[0]);  check("b4", b4, lvl[1]);
        check("at4", at4, tk[0]); check("bt4", bt4, tk[1]);
        check("a1", a1, lvl[2]);  check("b1", b1, lvl[3]);
        check("at1", at1, tk[2]); check("bt1", bt1, tk[3]);
    end

    task automatic rise_window();
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("lit_a4", a4, n >= 7);  check("lit_at4", at4, n == 7);
            check("lit_b4", b4, n >= 7);  check("lit_bt4", bt4, n == 7);
            check("lit_a1", a1, n >= 4);  check("lit_at1", at1, n == 4);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_a4", a4, 1'b0);
        check("rst_at4", at4, 1'b0);
        reset = 1'b1;
        rise_window();
        sw_a_raw = 1'b0;
        repeat (3) @(negedge clk);
        sw_a_raw = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("short_drop_a4", a4, 1'b1);
            check("short_drop_at4", at4, 1'b0);
        end
        sw_a_raw = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("fall_a4", a4, n < 7);
            check("fall_at4", at4, 1'b0);
            check("fall_b4", b4, 1'b1);
        end
        for (int n = 0; n < 8; n++) begin
            sw_a_raw = (n % 4) < 2;
            @(negedge clk);
            check("bounce_a4", a4, 1'b0);
            check("bounce_at4", at4, 1'b0);
        end
        sw_a_raw = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("settle_a4", a4, n >= 7);
            check("settle_at4", at4, n == 7);
        end
        sw_a_raw = 1'b0;
        sw_b_raw = 1'b0;
        repeat (8) @(negedge clk);
        check("both_low_a4", a4, 1'b0);
        check("both_low_b4", b4, 1'b0);
        sw_a_raw = 1'b1;
        sw_b_raw = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_a1", a1, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_a1", a1, 1'b0);
        check("async_rst_b1", b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        rise_window();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) sw_a_raw = ~sw_a_raw;
            if ($urandom_range(0, 5) == 0) sw_b_raw = ~sw_b_raw;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
